// File: rtl/audio_window_scheduler_pkg.sv
// rtl/audio_window_scheduler_pkg.sv - shared types, states and sample helpers for the window scheduler
package audio_pkg;

    typedef logic signed [15:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        BUSY
    } sched_state_t;

    localparam int DEFAULT_WINDOW_SIZE = 2048;

    // Unsigned magnitude, so -32768 becomes 32768 rather than wrapping negative.
    function automatic logic [15:0] sample_mag(input sample_t s);
        logic [15:0] u;
        u = s;
        return u[15] ? (~u + 16'd1) : u;
    endfunction

endpackage

// File: rtl/audio_window_scheduler_if.sv
// rtl/audio_window_scheduler_if.sv - capture, window-memory and engine handshake signals of the scheduler
interface audio_window_scheduler_if #(
    parameter int AW = 12
);
    logic          enable_in;
    logic [15:0]   sample_in;
    logic          sample_valid_in;
    logic          mem_we_out;
    logic [AW-1:0] mem_addr_out;
    logic [15:0]   mem_data_out;
    logic          eng_start_out;
    logic          eng_bank_out;
    logic          eng_done_in;
    logic          busy_out;
    logic          overrun_out;
    logic [15:0]   overrun_count_out;

    modport slave (
        input  enable_in, sample_in, sample_valid_in, eng_done_in,
        output mem_we_out, mem_addr_out, mem_data_out, eng_start_out,
               eng_bank_out, busy_out, overrun_out, overrun_count_out
    );

    modport master (
        output enable_in, sample_in, sample_valid_in, eng_done_in,
        input  mem_we_out, mem_addr_out, mem_data_out, eng_start_out,
               eng_bank_out, busy_out, overrun_out, overrun_count_out
    );
endinterface

// File: rtl/audio_window_scheduler_window_peak_tracker.sv
// rtl/audio_window_scheduler_window_peak_tracker.sv - running peak magnitude of the window being filled
module window_peak_tracker
    import audio_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        update,
    input  sample_t     sample,
    output logic [15:0] peak
);
    logic [15:0] peak_q;
    logic [15:0] mag;

    assign mag  = sample_mag(sample);
    // Includes the sample being accepted this cycle, so the last sample of a window counts.
    assign peak = (update && (mag > peak_q)) ? mag : peak_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q <= '0;
        end else if (clear) begin
            peak_q <= '0;
        end else if (update) begin
            peak_q <= peak;
        end
    end
endmodule

// File: rtl/audio_window_scheduler.sv
// rtl/audio_window_scheduler.sv - ping-pong window packer and engine dispatcher; AUDIO_GATE_EN adds peak gating
module audio_window_scheduler
    import audio_pkg::*;
#(
    parameter int          WINDOW_SIZE    = DEFAULT_WINDOW_SIZE,
    parameter logic [15:0] GATE_THRESHOLD = 16'd512
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    audio_window_scheduler_if.slave  bus
);
    localparam int             IW       = $clog2(WINDOW_SIZE);
    localparam logic [IW-1:0]  LAST_IDX = IW'(WINDOW_SIZE - 1);

    sched_state_t  state, state_next;
    logic          wr_bank;
    logic [IW-1:0] wr_idx;
    logic          pending, pend_bank, eng_bank;
    logic          accept, win_done, release_now, owned, other_free;
    logic          gated, commit, overrun_now;
    logic          start, busy;

    logic          mem_we_q;
    logic [IW:0]   mem_addr_q;
    sample_t       mem_data_q;
    logic          overrun_q;
    logic [15:0]   overrun_cnt_q;

    assign accept      = bus.sample_valid_in && bus.enable_in;
    assign win_done    = accept && (wr_idx == LAST_IDX);
    // A done arriving with a window completion frees the bank before the writer looks at it.
    assign release_now = (state == BUSY) && bus.eng_done_in;
    assign owned       = (state != IDLE) && !release_now;
    assign other_free  = !(pending && (pend_bank != wr_bank)) && !(owned && (eng_bank != wr_bank));

`ifdef AUDIO_GATE_EN
    logic [15:0] peak;

    window_peak_tracker u_peak (
        .clk    (clk_in),
        .rst_n  (rst_n_in),
        .clear  (win_done || !bus.enable_in),
        .update (accept),
        .sample (sample_t'(bus.sample_in)),
        .peak   (peak)
    );

    assign gated = win_done && (peak < GATE_THRESHOLD);
`else
    logic unused_gate;
    assign unused_gate = ^GATE_THRESHOLD;
    assign gated       = 1'b0;
`endif

    assign commit      = win_done && !gated && other_free;
    assign overrun_now = win_done && !gated && !other_free;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_q    <= '0;
            wr_idx        <= '0;
            wr_bank       <= 1'b0;
            overrun_q     <= 1'b0;
            overrun_cnt_q <= '0;
        end else begin
            mem_we_q <= accept;
            if (accept) begin
                mem_addr_q <= {wr_bank, wr_idx};
                mem_data_q <= sample_t'(bus.sample_in);
            end
            // Power-of-two window: the index wraps to 0 on completion by itself.
            if (!bus.enable_in) begin
                wr_idx <= '0;
            end else if (accept) begin
                wr_idx <= wr_idx + 1'b1;
            end
            if (commit) begin
                wr_bank <= ~wr_bank;
            end
            overrun_q <= overrun_now;
            if (overrun_now && (overrun_cnt_q != 16'hFFFF)) begin
                overrun_cnt_q <= overrun_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pending   <= 1'b0;
            pend_bank <= 1'b0;
            eng_bank  <= 1'b0;
        end else begin
            if (commit) begin
                pending   <= 1'b1;
                pend_bank <= wr_bank;
            end else if (state == DISPATCH) begin
                pending <= 1'b0;
            end
            if ((state == IDLE) && pending) begin
                eng_bank <= pend_bank;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    state_next = DISPATCH;
                end
            end
            DISPATCH: begin
                start      = 1'b1;
                state_next = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (bus.eng_done_in) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.mem_we_out        = mem_we_q;
    assign bus.mem_addr_out      = mem_addr_q;
    assign bus.mem_data_out      = mem_data_q;
    assign bus.eng_start_out     = start;
    assign bus.eng_bank_out      = eng_bank;
    assign bus.busy_out          = busy;
    assign bus.overrun_out       = overrun_q;
    assign bus.overrun_count_out = overrun_cnt_q;
endmodule

// File: tb/tb_audio_window_scheduler.sv
// tb/tb_audio_window_scheduler.sv - directed bench for audio_window_scheduler with an 8-sample window
module tb_audio_window_scheduler;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   start_cnt = 0;
    int   sc;

`ifdef AUDIO_GATE_EN
    localparam int BASE = 1000;
`else
    localparam int BASE = 0;
`endif

    audio_window_scheduler_if #(.AW(4)) bus ();

    audio_window_scheduler #(
        .WINDOW_SIZE    (8),
        .GATE_THRESHOLD (16'd512)
    ) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.eng_start_out === 1'b1) start_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] v);
        bus.sample_valid_in = 1'b1;
        bus.sample_in       = v;
        tick();
        bus.sample_valid_in = 1'b0;
    endtask

    task automatic done_pulse();
        bus.eng_done_in = 1'b1;
        tick();
        bus.eng_done_in = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"},    32'(bus.mem_we_out), 0);
        chk({tag, "_addr"},  32'(bus.mem_addr_out), 0);
        chk({tag, "_data"},  32'(bus.mem_data_out), 0);
        chk({tag, "_start"}, 32'(bus.eng_start_out), 0);
        chk({tag, "_bank"},  32'(bus.eng_bank_out), 0);
        chk({tag, "_busy"},  32'(bus.busy_out), 0);
        chk({tag, "_ovr"},   32'(bus.overrun_out), 0);
        chk({tag, "_cnt"},   32'(bus.overrun_count_out), 0);
    endtask

`ifdef AUDIO_GATE_EN
    task automatic send_window(input logic [15:0] special);
        for (int i = 0; i < 8; i++) begin
            if (i == 3)      send(special);
            else if (i % 2)  send(16'hFF9C);
            else             send(16'd100);
        end
    endtask
`endif

    initial begin
        rst_n               = 1'b0;
        bus.enable_in       = 1'b0;
        bus.sample_in       = '0;
        bus.sample_valid_in = 1'b0;
        bus.eng_done_in     = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst_n         = 1'b1;
        bus.enable_in = 1'b1;
        tick();

        // First window into bank 0 with the engine idle
        for (int i = 0; i < 8; i++) begin
            send(16'(BASE + i + 1));
            chk("w1_we",   32'(bus.mem_we_out), 1);
            chk("w1_addr", 32'(bus.mem_addr_out), 32'(i));
            chk("w1_data", 32'(bus.mem_data_out), 32'(BASE + i + 1));
        end
        chk("w1_start_early", 32'(bus.eng_start_out), 0);
        tick();
        chk("w1_start", 32'(bus.eng_start_out), 1);
        chk("w1_bank",  32'(bus.eng_bank_out), 0);
        tick();
        chk("w1_start_once", 32'(bus.eng_start_out), 0);
        chk("w1_busy",       32'(bus.busy_out), 1);
        send(16'(BASE + 9));
        chk("w2_addr0", 32'(bus.mem_addr_out), 8);
        chk("w2_data0", 32'(bus.mem_data_out), 32'(BASE + 9));

        // Bank 1 completes while bank 0 is still engine-owned
        for (int i = 1; i < 8; i++) send(16'(BASE + 9 + i));
        chk("ovr_addr",  32'(bus.mem_addr_out), 15);
        chk("ovr_pulse", 32'(bus.overrun_out), 1);
        chk("ovr_count", 32'(bus.overrun_count_out), 1);
        tick();
        chk("ovr_pulse_end", 32'(bus.overrun_out), 0);
        chk("ovr_still_busy", 32'(bus.busy_out), 1);
        chk("ovr_starts", 32'(start_cnt), 1);

        // Done coincides with bank 1 completing: no overrun, bank 1 dispatched
        for (int i = 0; i < 7; i++) send(16'(BASE + 20 + i));
        bus.eng_done_in = 1'b1;
        send(16'(BASE + 27));
        bus.eng_done_in = 1'b0;
        chk("sim_addr",  32'(bus.mem_addr_out), 15);
        chk("sim_ovr",   32'(bus.overrun_out), 0);
        chk("sim_count", 32'(bus.overrun_count_out), 1);
        chk("sim_busy",  32'(bus.busy_out), 0);
        chk("sim_start_early", 32'(bus.eng_start_out), 0);
        tick();
        chk("sim_start", 32'(bus.eng_start_out), 1);
        chk("sim_bank",  32'(bus.eng_bank_out), 1);
        tick();
        chk("sim_busy2", 32'(bus.busy_out), 1);
        done_pulse();
        chk("rel_busy", 32'(bus.busy_out), 0);
        done_pulse();
        chk("stray_done_busy", 32'(bus.busy_out), 0);
        chk("stray_done_starts", 32'(start_cnt), 2);

        // Partial window discarded by enable drop
        sc = start_cnt;
        for (int i = 0; i < 5; i++) send(16'(BASE + 40 + i));
        bus.enable_in       = 1'b0;
        bus.sample_valid_in = 1'b1;
        bus.sample_in       = 16'h7777;
        tick();
        bus.sample_valid_in = 1'b0;
        chk("dis_we", 32'(bus.mem_we_out), 0);
        bus.enable_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(16'(BASE + 50 + i));
            chk("en_addr", 32'(bus.mem_addr_out), 32'(i));
        end
        tick();
        tick();
        chk("en_one_start", 32'(start_cnt), 32'(sc + 1));
        chk("en_bank",      32'(bus.eng_bank_out), 0);
        chk("en_busy",      32'(bus.busy_out), 1);

        // Reset while the engine owns a bank
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_busy");
        tick();
        tick();
        rst_n = 1'b1;
        sc    = start_cnt;
        done_pulse();
        tick();
        tick();
        chk("rst_no_busy",  32'(bus.busy_out), 0);
        chk("rst_no_start", 32'(start_cnt), 32'(sc));
        send(16'(BASE + 60));
        chk("rst_addr", 32'(bus.mem_addr_out), 0);
        bus.enable_in = 1'b0;
        tick();
        bus.enable_in = 1'b1;

`ifdef AUDIO_GATE_EN
        sc = start_cnt;
        send_window(16'd100);
        repeat (3) tick();
        chk("gate_quiet_start", 32'(start_cnt), 32'(sc));
        chk("gate_quiet_ovr",   32'(bus.overrun_count_out), 0);
        send_window(16'h8000);
        repeat (3) tick();
        chk("gate_min_start", 32'(start_cnt), 32'(sc + 1));
        chk("gate_min_bank",  32'(bus.eng_bank_out), 0);
        done_pulse();
        send_window(16'd511);
        repeat (3) tick();
        chk("gate_511_start", 32'(start_cnt), 32'(sc + 1));
        send_window(16'd512);
        repeat (3) tick();
        chk("gate_512_start", 32'(start_cnt), 32'(sc + 2));
        chk("gate_512_bank",  32'(bus.eng_bank_out), 1);
        chk("gate_ovr",       32'(bus.overrun_count_out), 0);
        done_pulse();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
